dmem_arbiter: RTL and testbench

- Shares the single data-RAM port between two requesters: the core's load/store path (CPU) and a debug/boot-loader port (DBG).
- Provides fixed-priority arbitration with CPU first, plus a starvation guard for DBG.
- Provides a halt handshake that drains outstanding CPU reads, stalls the core and gives DBG exclusive memory access.
- Sits between the memory stage and the data block RAM, which has one-cycle read latency.

---
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-RAM port arbiter: CPU-first priority with a DBG starvation guard
// and a halt handshake that drains CPU reads before granting DBG exclusivity.
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_halt_req,
  output logic              dbg_halt_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  localparam logic [7:0] SMAX = 8'(STARVE_MAX);

  state_t     state, state_nx;
  logic [7:0] starve_cnt, starve_nx;
  logic       cpu_pend, dbg_pend;
  logic       cpu_win, dbg_win;
  logic       unused;

  // Address bits outside the RAM word index alias by design.
  assign unused = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                    dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (!rst) begin
      if (state == RUN)
        cpu_win = cpu_req && !(dbg_req && starve_cnt == SMAX);
      dbg_win = dbg_req && !cpu_win;
    end
  end

  assign cpu_gnt   = cpu_win;
  assign dbg_gnt   = dbg_win;
  assign mem_en    = cpu_win | dbg_win;
  assign mem_we    = cpu_win ? cpu_we : (dbg_win & dbg_we);
  assign mem_addr  = cpu_win ? cpu_addr[ADDR_W+1:2] :
                     dbg_win ? dbg_addr[ADDR_W+1:2] : '0;
  assign mem_wdata = cpu_win ? cpu_wdata :
                     dbg_win ? dbg_wdata : '0;

  assign cpu_rvalid   = cpu_pend && !rst;
  assign dbg_rvalid   = dbg_pend && !rst;
  assign cpu_rdata    = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata    = dbg_rvalid ? mem_rdata : '0;
  assign cpu_stall    = !rst && ((cpu_req && !cpu_win) || state != RUN);
  assign dbg_halt_ack = !rst && state == HALTED;

  always_comb begin
    state_nx  = state;
    starve_nx = starve_cnt;
    unique case (state)
      RUN: begin
        if (dbg_halt_req)
          state_nx = DRAIN;
        if (dbg_req && !dbg_win)
          starve_nx = (starve_cnt == SMAX) ? starve_cnt
                                           : starve_cnt + 8'd1;
        else
          starve_nx = '0;
      end
      DRAIN: begin
        if (!dbg_halt_req)
          state_nx = RUN;
        else if (!cpu_pend)
          state_nx = HALTED;
      end
      HALTED: begin
        if (!dbg_halt_req)
          state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      starve_cnt <= '0;
      cpu_pend   <= 1'b0;
      dbg_pend   <= 1'b0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      cpu_pend   <= cpu_win && !cpu_we;
      dbg_pend   <= dbg_win && !dbg_we;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the arbiter.
module tb_dmem_arbiter;

  localparam int SMAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        dbg_halt_req, dbg_halt_ack;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad = 0;

  // RAM environment: one-cycle read latency
  logic [31:0] ram [0:4095];
  logic [31:0] rd_q = '0;
  assign mem_rdata = rd_q;
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else rd_q <= ram[mem_addr];
    end

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .dbg_halt_req(dbg_halt_req),
    .dbg_halt_ack(dbg_halt_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural model: 0=running 1=draining 2=halted
  int          ms, mcnt;
  bit          mcp, mdp;
  logic [31:0] mcd, mdd;
  logic [31:0] mm [0:4095];
  bit          e_cg, e_dg, e_en, e_we, e_crv, e_drv, e_st, e_ack;
  logic [11:0] e_addr;
  logic [31:0] e_wd, e_crd, e_drd;

  task automatic eval();
    {e_cg, e_dg, e_en, e_we, e_crv, e_drv, e_st, e_ack} = '0;
    e_addr = '0; e_wd = '0; e_crd = '0; e_drd = '0;
    if (!rst) begin
      e_cg = ms == 0 && cpu_req && !(dbg_req && mcnt == SMAX);
      e_dg = dbg_req && !e_cg;
      e_en = e_cg || e_dg;
      if (e_cg) begin
        e_we = cpu_we; e_addr = cpu_addr[13:2]; e_wd = cpu_wdata;
      end else if (e_dg) begin
        e_we = dbg_we; e_addr = dbg_addr[13:2]; e_wd = dbg_wdata;
      end
      e_crv = mcp; e_crd = mcp ? mcd : '0;
      e_drv = mdp; e_drd = mdp ? mdd : '0;
      e_st  = (cpu_req && !e_cg) || ms != 0;
      e_ack = ms == 2;
    end
  endtask

  task automatic update();
    int nxt;
    logic [31:0] d;
    if (rst) begin
      ms = 0; mcnt = 0; mcp = 0; mdp = 0;
    end else begin
      nxt = ms;
      if (ms == 0 && dbg_halt_req) nxt = 1;
      else if (ms == 1) nxt = !dbg_halt_req ? 0 : (!mcp ? 2 : 1);
      else if (ms == 2 && !dbg_halt_req) nxt = 0;
      if (ms == 0)
        mcnt = (dbg_req && !e_dg) ? (mcnt < SMAX ? mcnt + 1 : mcnt) : 0;
      d = mm[e_addr];
      mcp = e_cg && !cpu_we; mcd = d;
      mdp = e_dg && !dbg_we; mdd = d;
      if (e_en && e_we) mm[e_addr] = e_wd;
      ms = nxt;
    end
  endtask

  task automatic settle();
    #1 eval();
  endtask

  task automatic adv();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    dbg_halt_req = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); cpu_req = 1; dbg_req = 1; dbg_halt_req = 1;
    adv(); adv(); settle();
    total++;
    if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_stall,
         dbg_halt_ack, mem_en, mem_we} !== 8'h00) begin
      bad++; $display("FAIL reset_ctl got=%b want=0", {cpu_gnt, dbg_gnt,
        cpu_rvalid, dbg_rvalid, cpu_stall, dbg_halt_ack, mem_en, mem_we});
    end
    total++;
    if ({mem_addr, mem_wdata, cpu_rdata, dbg_rdata} !== '0) begin
      bad++; $display("FAIL reset_data got=%h want=0",
        {mem_addr, mem_wdata, cpu_rdata, dbg_rdata});
    end
    rst = 0; idle(); settle(); adv();
    settle();
    total++;
    if (dbg_halt_ack !== 0 || cpu_stall !== 0) begin
      bad++; $display("FAIL reset_release ack=%b stall=%b want 0 0",
        dbg_halt_ack, cpu_stall);
    end
    adv();
  endtask

  task automatic test_cpu_read();
    ram[4] = 32'hDEADBEEF; mm[4] = 32'hDEADBEEF;
    idle(); cpu_req = 1; cpu_addr = 32'h10; settle();
    total++;
    if (cpu_gnt !== 1 || mem_en !== 1 || mem_we !== 0 || mem_addr !== 12'd4)
    begin
      bad++; $display("FAIL cpu_rd_gnt gnt=%b en=%b we=%b addr=%0d want 1 1 0 4",
        cpu_gnt, mem_en, mem_we, mem_addr);
    end
    adv(); idle(); settle();
    total++;
    if (cpu_rvalid !== 1 || cpu_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL cpu_rd_data rv=%b d=%h want 1 deadbeef",
        cpu_rvalid, cpu_rdata);
    end
    total++;
    if (dbg_rdata !== 0 || dbg_rvalid !== 0) begin
      bad++; $display("FAIL cpu_rd_dbgside rv=%b d=%h want 0 0",
        dbg_rvalid, dbg_rdata);
    end
    adv();
  endtask

  task automatic test_starve();
    bit want_d;
    idle(); settle(); adv();
    for (int i = 0; i < 27; i++) begin
      cpu_req = 1; cpu_addr = 32'(i * 4); dbg_req = 1; dbg_addr = 32'h400;
      settle();
      want_d = (i % 9) == 8;
      total++;
      if (cpu_gnt !== !want_d || dbg_gnt !== want_d) begin
        bad++; $display("FAIL starve_cyc%0d cpu=%b dbg=%b want %b %b",
          i, cpu_gnt, dbg_gnt, !want_d, want_d);
      end
      adv();
    end
    idle(); settle(); adv();
  endtask

  task automatic test_dbg_wr_rd();
    idle(); dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20;
    dbg_wdata = 32'h12345678; settle();
    total++;
    if (dbg_gnt !== 1 || mem_we !== 1 || mem_addr !== 12'd8 ||
        mem_wdata !== 32'h12345678) begin
      bad++; $display("FAIL dbg_wr gnt=%b we=%b addr=%0d wd=%h want 1 1 8 12345678",
        dbg_gnt, mem_we, mem_addr, mem_wdata);
    end
    adv(); dbg_we = 0; settle();
    total++;
    if (dbg_rvalid !== 0 || dbg_gnt !== 1 || mem_we !== 0) begin
      bad++; $display("FAIL dbg_rd_gnt rv=%b gnt=%b we=%b want 0 1 0",
        dbg_rvalid, dbg_gnt, mem_we);
    end
    adv(); idle(); settle();
    total++;
    if (dbg_rvalid !== 1 || dbg_rdata !== 32'h12345678 || cpu_rdata !== 0) begin
      bad++; $display("FAIL dbg_rd_data rv=%b d=%h cd=%h want 1 12345678 0",
        dbg_rvalid, dbg_rdata, cpu_rdata);
    end
    adv();
  endtask

  task automatic test_halt();
    idle(); cpu_req = 1; cpu_addr = 32'h40; dbg_halt_req = 1; settle();
    total++;
    if (cpu_gnt !== 1 || dbg_halt_ack !== 0) begin
      bad++; $display("FAIL halt_c0 gnt=%b ack=%b want 1 0", cpu_gnt, dbg_halt_ack);
    end
    adv(); settle();
    total++;
    if (cpu_rvalid !== 1 || cpu_rdata !== e_crd || cpu_stall !== 1 ||
        cpu_gnt !== 0 || dbg_halt_ack !== 0) begin
      bad++; $display("FAIL halt_c1 rv=%b d=%h st=%b gnt=%b ack=%b want 1 %h 1 0 0",
        cpu_rvalid, cpu_rdata, cpu_stall, cpu_gnt, dbg_halt_ack, e_crd);
    end
    adv(); settle();
    total++;
    if (dbg_halt_ack !== 0 || cpu_stall !== 1) begin
      bad++; $display("FAIL halt_c2 ack=%b st=%b want 0 1", dbg_halt_ack, cpu_stall);
    end
    adv(); dbg_req = 1; dbg_addr = 32'h40; settle();
    total++;
    if (dbg_halt_ack !== 1 || cpu_gnt !== 0 || dbg_gnt !== 1) begin
      bad++; $display("FAIL halt_c3 ack=%b cgnt=%b dgnt=%b want 1 0 1",
        dbg_halt_ack, cpu_gnt, dbg_gnt);
    end
    adv(); dbg_req = 0; dbg_halt_req = 0; settle();
    total++;
    if (dbg_halt_ack !== 1 || cpu_gnt !== 0 || dbg_rvalid !== 1) begin
      bad++; $display("FAIL halt_c4 ack=%b cgnt=%b drv=%b want 1 0 1",
        dbg_halt_ack, cpu_gnt, dbg_rvalid);
    end
    adv(); settle();
    total++;
    if (dbg_halt_ack !== 0 || cpu_gnt !== 1 || cpu_stall !== 0) begin
      bad++; $display("FAIL halt_exit ack=%b gnt=%b st=%b want 0 1 0",
        dbg_halt_ack, cpu_gnt, cpu_stall);
    end
    adv(); idle(); settle(); adv();
  endtask

  task automatic test_halt_pulse();
    int acks = 0;
    idle(); dbg_halt_req = 1; settle(); adv();
    dbg_halt_req = 0; settle();
    total++;
    if (cpu_stall !== 1) begin
      bad++; $display("FAIL pulse_drain stall=%b want 1", cpu_stall);
    end
    acks += int'(dbg_halt_ack);
    for (int i = 0; i < 4; i++) begin
      adv(); settle(); acks += int'(dbg_halt_ack);
    end
    total++;
    if (acks !== 0 || cpu_stall !== 0) begin
      bad++; $display("FAIL pulse_noack acks=%0d stall=%b want 0 0", acks, cpu_stall);
    end
    adv();
  endtask

  task automatic test_reset_mid();
    idle(); cpu_req = 1; cpu_addr = 32'h44; settle(); adv();
    rst = 1; settle();
    total++;
    if ({cpu_rvalid, cpu_gnt, mem_en, cpu_stall} !== 4'b0 || cpu_rdata !== 0) begin
      bad++; $display("FAIL rst_inflight rv=%b gnt=%b en=%b st=%b d=%h want 0",
        cpu_rvalid, cpu_gnt, mem_en, cpu_stall, cpu_rdata);
    end
    adv(); rst = 0; idle(); settle();
    total++;
    if (cpu_rvalid !== 0 || dbg_halt_ack !== 0) begin
      bad++; $display("FAIL rst_after rv=%b ack=%b want 0 0", cpu_rvalid, dbg_halt_ack);
    end
    dbg_halt_req = 1;
    for (int i = 0; i < 3; i++) begin
      adv(); settle();
    end
    total++;
    if (dbg_halt_ack !== 1) begin
      bad++; $display("FAIL rst_prehalt ack=%b want 1", dbg_halt_ack);
    end
    rst = 1; dbg_halt_req = 0; settle(); adv();
    rst = 0; cpu_req = 1; settle();
    total++;
    if (dbg_halt_ack !== 0 || cpu_gnt !== 1 || cpu_stall !== 0) begin
      bad++; $display("FAIL rst_halted ack=%b gnt=%b st=%b want 0 1 0",
        dbg_halt_ack, cpu_gnt, cpu_stall);
    end
    adv(); idle(); settle(); adv();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 59) == 0;
      cpu_req = $urandom_range(0, 3) != 0; cpu_we = $urandom_range(0, 2) == 0;
      cpu_addr = $urandom; cpu_wdata = $urandom;
      dbg_req = $urandom_range(0, 1) == 1; dbg_we = $urandom_range(0, 2) == 0;
      dbg_addr = $urandom & 32'hFFFF_F03F; dbg_wdata = $urandom;
      if ($urandom_range(0, 19) == 0) dbg_halt_req = !dbg_halt_req;
      settle();
      total++;
      if ({cpu_gnt, dbg_gnt, mem_en, mem_we, cpu_rvalid, dbg_rvalid,
           cpu_stall, dbg_halt_ack} !==
          {e_cg, e_dg, e_en, e_we, e_crv, e_drv, e_st, e_ack}) begin
        bad++; $display("FAIL rnd_ctl cyc%0d got=%b want=%b", i,
          {cpu_gnt, dbg_gnt, mem_en, mem_we, cpu_rvalid, dbg_rvalid,
           cpu_stall, dbg_halt_ack},
          {e_cg, e_dg, e_en, e_we, e_crv, e_drv, e_st, e_ack});
      end
      total++;
      if ({mem_addr, mem_wdata, cpu_rdata, dbg_rdata} !==
          {e_addr, e_wd, e_crd, e_drd}) begin
        bad++; $display("FAIL rnd_data cyc%0d got=%h want=%h", i,
          {mem_addr, mem_wdata, cpu_rdata, dbg_rdata},
          {e_addr, e_wd, e_crd, e_drd});
      end
      adv();
    end
    rst = 0; idle(); settle(); adv();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 32'(i) ^ 32'hA5A5_0000;
      mm[i]  = 32'(i) ^ 32'hA5A5_0000;
    end
    ms = 0; mcnt = 0; mcp = 0; mdp = 0; mcd = '0; mdd = '0;
    rst = 1; idle();
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_starve();
    test_dbg_wr_rd();
    test_halt();
    test_halt_pulse();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
